serial_mag_comparator_ctrl: RTL and testbench

- Bit-serial N-bit magnitude comparator controller.
- Sequences a single 1-bit gate-level comparator slice (GT = A&~B, LT = ~A&B, EQ = A XNOR B) over two latched N-bit operands, MSB first.
- Terminates early at the first differing bit and reports one-hot GT/EQ/LT with a done pulse.
- Sits beside the combinational comparator library as the area-minimal alternative to a WIDTH-bit parallel compare.

---
 rtl/serial_mag_comparator_ctrl.sv | 132 +++++++++++++
 tb/tb_serial_mag_comparator_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_comparator_ctrl.sv
// Bit-serial unsigned magnitude comparator: walks one gate-level slice over two
// latched operands MSB first and stops at the first differing bit.
module serial_mag_comparator_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             GT,
  output logic             EQ,
  output logic             LT
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               gt_q, gt_d;
  logic               eq_q, eq_d;
  logic               lt_q, lt_d;

  logic               bit_a, bit_b;
  logic               slice_gt, slice_lt, slice_eq;

  // The single 1-bit comparator slice, fed from the current scan position.
  always_comb begin
    bit_a    = a_q[idx_q];
    bit_b    = b_q[idx_q];
    slice_gt = bit_a & ~bit_b;
    slice_lt = ~bit_a & bit_b;
    slice_eq = ~(bit_a ^ bit_b);
  end

  // Next-state, operand capture, index and result update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          idx_d   = IDX_W'(WIDTH - 1);
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (slice_gt) begin
          gt_d    = 1'b1;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = DONE;
        end else if (slice_lt) begin
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b1;
          state_d = DONE;
        end else if (slice_eq && (idx_q == {IDX_W{1'b0}})) begin
          gt_d    = 1'b0;
          eq_d    = 1'b1;
          lt_d    = 1'b0;
          state_d = DONE;
        end else begin
          // Bits equal with lower bits still to examine; index stays above 0 here.
          idx_d   = idx_q - IDX_W'(1);
          state_d = SCAN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == SCAN);
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign GT   = gt_q;
  assign EQ   = eq_q;
  assign LT   = lt_q;

endmodule

// File: tb/tb_serial_mag_comparator_ctrl.sv
// Directed bench for serial_mag_comparator_ctrl: an 8-bit and a 1-bit instance,
// with a scoreboard of expected results and latencies for the 8-bit one.
module tb_serial_mag_comparator_ctrl;

  logic       clk;
  logic       rst;
  logic       start, start1;
  logic [7:0] a8, b8;
  logic [0:0] a1, b1;
  logic       busy, done, gt, eq, lt;
  logic       busy1, done1, gt1, eq1, lt1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0] res;  // {GT, EQ, LT}
    int         lat;  // cycle after the accepting edge in which done is high
  } exp_t;

  exp_t exp_q[$];

  serial_mag_comparator_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .A(a8), .B(b8),
    .busy(busy), .done(done), .GT(gt), .EQ(eq), .LT(lt)
  );

  serial_mag_comparator_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1),
    .busy(busy1), .done(done1), .GT(gt1), .EQ(eq1), .LT(lt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: unsigned ordering plus the MSB-first position of the first difference.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    logic found;
    found = 1'b0;
    e.lat = 9;
    for (int i = 7; i >= 0; i--) begin
      if (!found && (a[i] !== b[i])) begin
        found = 1'b1;
        e.lat = 8 - i + 1;
      end
    end
    e.res = (a > b) ? 3'b100 : ((a < b) ? 3'b001 : 3'b010);
    return e;
  endfunction

  // Drives one start cycle; on return we are in cycle 1 after the accepting edge.
  task automatic start_cmp(input logic [7:0] a, input logic [7:0] b);
    a8 = a;
    b8 = b;
    start = 1'b1;
    exp_q.push_back(model(a, b));
    tick();
    start = 1'b0;
  endtask

  // Bounded wait for done starting from cycle c0; pops and checks the scoreboard.
  task automatic wait_done(input string tag, input int c0);
    int   c;
    exp_t e;
    c = c0;
    while (!done && c < 40) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      tick();
      c++;
    end
    if (!done) begin
      chk({tag, "_timeout"}, 32'(done), 32'd1);
      exp_q.delete();
    end else if (exp_q.size() == 0) begin
      chk({tag, "_unexpected_done"}, 32'(done), 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_latency"}, 32'(c), 32'(e.lat));
      chk({tag, "_result"}, 32'({gt, eq, lt}), 32'(e.res));
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int dcount;
    rst = 1'b1; start = 1'b0; start1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; a1 = 1'b0; b1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_w8", 32'({busy, done, gt, eq, lt}), 32'd0);
    chk("reset_w1", 32'({busy1, done1, gt1, eq1, lt1}), 32'd0);
    tick();
    chk("idle_no_result", 32'({busy, done, gt, eq, lt}), 32'd0);

    // MSB differs: shortest compare
    start_cmp(8'hA5, 8'h25);
    wait_done("a5_25", 1);
    tick();
    chk("a5_25_done_pulse", 32'({busy, done}), 32'd0);

    // Equal operands scan every bit; a start during DONE must be dropped
    start_cmp(8'h3C, 8'h3C);
    wait_done("eq_3c", 1);
    a8 = 8'h01; b8 = 8'h02; start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_done_ignored", 32'({busy, done}), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("eq_hold", 32'({done, gt, eq, lt}), 32'b0010);
      tick();
    end

    // Difference only in the LSB, then back-to-back start in the following IDLE cycle
    start_cmp(8'h10, 8'h11);
    wait_done("lsb_10_11", 1);
    tick();
    chk("lsb_hold_idle", 32'({busy, done, gt, eq, lt}), 32'b00001);
    start_cmp(8'hFF, 8'h00);
    wait_done("b2b_ff_00", 1);

    // A second start and operand toggling during SCAN must not disturb the compare
    tick();
    start_cmp(8'h00, 8'h01);
    tick();
    tick();
    a8 = 8'hFF; b8 = 8'h00; start = 1'b1;
    tick();
    start = 1'b0; a8 = 8'h5A; b8 = 8'hC3;
    chk("busy_after_ignored_start", 32'(busy), 32'd1);
    wait_done("ignored_start", 4);
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) dcount++;
    end
    chk("single_done_pulse", 32'(dcount), 32'd0);
    chk("ignored_start_held", 32'({gt, eq, lt}), 32'b001);

    // Reset during SCAN abandons the compare with no done pulse
    start_cmp(8'h80, 8'h80);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("midop_reset", 32'({busy, done, gt, eq, lt}), 32'd0);
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) dcount++;
      tick();
    end
    chk("no_done_after_reset", 32'(dcount), 32'd0);
    start_cmp(8'h01, 8'h00);
    wait_done("fresh_01_00", 1);

    // WIDTH=1 instance: every operand pair finishes in cycle 2
    for (int k = 0; k < 4; k++) begin
      logic [1:0] ab;
      logic [2:0] want;
      ab = 2'(k);
      a1 = ab[1];
      b1 = ab[0];
      want = (ab == 2'b10) ? 3'b100 : ((ab == 2'b01) ? 3'b001 : 3'b010);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("w1_cycle1", 32'({busy1, done1}), 32'b10);
      tick();
      chk("w1_cycle2", 32'({busy1, done1}), 32'b01);
      chk("w1_result", 32'({gt1, eq1, lt1}), 32'(want));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
